sobel_host_ctrl: RTL

- Host-side sequencer for the Sobel subsystem.
- Accepts a raster image as a valid/ready pixel stream and writes it into the input memory through the top-level load port.
- Then pulses start to the Sobel execution unit, waits for finish (with a watchdog), and reads the output memory back out as a valid/ready pixel stream.
- Sits between a host/DMA interface and the load/start/finish/readback pins of the Sobel top.

---
 rtl/sobel_host_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sobel_host_ctrl.sv
// Host-side sequencer for the Sobel subsystem: streams an image into the
// input memory, kicks the execution unit, waits for finish under a watchdog,
// then streams the output memory back out through a 2-entry skid FIFO.
module sobel_host_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int NUM_PIXELS     = 65536,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_start_i,
   input  logic                  cmd_abort_i,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  in_ready_o,
   output logic                  wr_en_imem_o,
   output logic [ADDR_WIDTH-1:0] addr_imem_o,
   output logic [DATA_WIDTH-1:0] data_imem_o,
   output logic                  exc_start_o,
   input  logic                  exc_finish_i,
   output logic                  rd_en_omem_o,
   output logic [ADDR_WIDTH-1:0] addr_omem_o,
   input  logic [DATA_WIDTH-1:0] data_omem_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   // One extra counter bit lets NUM_PIXELS == 2**ADDR_WIDTH terminate without wrap.
   localparam int CW = ADDR_WIDTH + 1;
   localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] NPIX    = CW'(NUM_PIXELS);
   localparam logic [CW-1:0] LAST    = CW'(NUM_PIXELS - 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_DONE
   } state_e;

   state_e                state_q;
   logic [CW-1:0]         ld_cnt_q, rd_cnt_q, pop_cnt_q;
   logic [WW-1:0]         wd_q;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            fifo_cnt_q;
   logic                  inflight_q;
   logic                  in_ready_q, start_q, rd_en_q, busy_q, done_q, err_q;

   logic                  wr_fire, pop, issue;
   logic [1:0]            occ;

   // Handshakes and read-issue decision. Occupancy is taken net of this
   // cycle's pop so a steady ready stream sustains one read per cycle.
   always_comb begin
      wr_fire = in_valid_i & in_ready_q;
      pop     = (fifo_cnt_q != 2'd0) & out_ready_i;
      occ     = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      issue   = rd_en_q & (rd_cnt_q < NPIX) & (occ < 2'd2);
   end

   assign in_ready_o   = in_ready_q;
   assign wr_en_imem_o = wr_fire;
   assign addr_imem_o  = ld_cnt_q[ADDR_WIDTH-1:0];
   assign data_imem_o  = in_ready_q ? in_data_i : '0;
   assign exc_start_o  = start_q;
   assign rd_en_omem_o = rd_en_q;
   assign addr_omem_o  = rd_cnt_q[ADDR_WIDTH-1:0];
   assign out_valid_o  = (fifo_cnt_q != 2'd0);
   assign out_data_o   = fifo_q[rd_ptr_q];
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

   // Job sequencer: state, counters, readback FIFO and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         ld_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         pop_cnt_q  <= '0;
         wd_q       <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
         inflight_q <= 1'b0;
         in_ready_q <= 1'b0;
         start_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         if (cmd_abort_i && state_q != S_IDLE) begin
            // Abort wins over everything; err_q deliberately left as is.
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            ld_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            wd_q       <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            inflight_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (cmd_start_i) begin
                     state_q    <= S_LOAD;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                     err_q      <= 1'b0;
                     ld_cnt_q   <= '0;
                  end
               end
               S_LOAD: begin
                  if (wr_fire) begin
                     ld_cnt_q <= ld_cnt_q + 1'b1;
                     if (ld_cnt_q == LAST) begin
                        state_q    <= S_START;
                        in_ready_q <= 1'b0;
                        start_q    <= 1'b1;
                     end
                  end
               end
               S_START: begin
                  state_q <= S_RUN;
                  wd_q    <= '0;
               end
               S_RUN: begin
                  // Saturate so wd_q != 0 keeps marking "not the first RUN cycle".
                  if (wd_q != '1) wd_q <= wd_q + 1'b1;
                  if (wd_q != '0 && exc_finish_i) begin
                     state_q    <= S_DRAIN;
                     rd_en_q    <= 1'b1;
                     rd_cnt_q   <= '0;
                     pop_cnt_q  <= '0;
                  end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
               S_DRAIN: begin
                  inflight_q <= issue;
                  if (issue) rd_cnt_q <= rd_cnt_q + 1'b1;
                  if (inflight_q) begin
                     fifo_q[wr_ptr_q] <= data_omem_i;
                     wr_ptr_q         <= ~wr_ptr_q;
                  end
                  if (pop) begin
                     rd_ptr_q  <= ~rd_ptr_q;
                     pop_cnt_q <= pop_cnt_q + 1'b1;
                  end
                  fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
                  if (pop && pop_cnt_q == LAST) begin
                     state_q <= S_DONE;
                     rd_en_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule
